fc_layer_sequencer: RTL and testbench
=====================================

# fc_layer_sequencer

Controller that sequences one shared multiply-accumulate PE through a fully connected layer of NO_INPUT inputs and NO_OUTPUT outputs. It generates input-buffer and weight-memory read addresses, the PE enable, clear and last strobes, and the output-buffer write strobe and address. It also provides a start/busy/done handshake to the layer-level scheduler. It replaces free-running index logic with an explicit FSM that has reset and a defined completion point.

## Interface
- NO_INPUT, 2, number of input activations (≥1)
- NO_OUTPUT, 2, number of output neurons (≥1)
- MAC_LAT, 1, cycles from mac_en to accumulated value visible on PE output (≥1)
- IW, $clog2(NO_INPUT) min 1, input address width
- OW, $clog2(NO_OUTPUT) min 1, output address width
- WW, $clog2(NO_INPUT*NO_OUTPUT) min 1, weight address width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a layer pass; sampled only in IDLE
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when pass complete
- rd_en  out  1  read strobe to input buffer and weight memory (1-cycle read latency)
- in_addr  out  IW  input index i
- w_addr  out  WW  weight index i*NO_OUTPUT + j (row-major weights[i][j])
- mac_en  out  1  PE accumulate enable
- mac_clear  out  1  with mac_en: acc = product, not acc + product
- mac_last  out  1  with mac_en: final term of current output
- out_we  out  1  output-buffer write strobe (captures PE result this cycle)
- out_addr  out  OW  output index j being written

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Counters: i (0..NO_INPUT-1) and j (0..NO_OUTPUT-1).
- IDLE
  - All outputs are 0.
  - start=1 → RUN, with i=0, j=0.
- RUN
  - Each cycle: rd_en=1, in_addr=i, w_addr=i*NO_OUTPUT+j.
  - i increments each cycle. At i=NO_INPUT-1, i wraps to 0 and j increments.
  - Issuing i=NO_INPUT-1, j=NO_OUTPUT-1 → DRAIN. Counters return to 0.
- Issue pipeline (1 stage, matching memory latency)
  - mac_en is rd_en delayed 1 cycle.
  - mac_clear is (i==0) delayed 1 cycle.
  - mac_last is (i==NO_INPUT-1) delayed 1 cycle.
  - Tag j travels with the pipeline.
- Writeback: out_we = mac_last delayed MAC_LAT cycles, and out_addr = the tag j delayed by the same amount. out_addr = 0 when out_we = 0.
- Outputs are processed back to back with no bubble. The clear on the next output's first term coincides with the previous output's writeback cycle (valid for MAC_LAT≥1).
- DRAIN: wait until the writeback pipeline is empty, i.e. the cycle after the final out_we → DONE.
- DONE: done=1 for one cycle → IDLE.
- start is ignored in RUN, DRAIN and DONE; it is not queued.
- NO_INPUT=1: every mac_en carries both mac_clear and mac_last.
- NO_OUTPUT=1: j stays 0.
- rst in any state
  - Next cycle: IDLE, counters 0, every pipeline stage cleared, all outputs 0.
  - No out_we or done pulse is produced for the aborted pass.

## Timing
- Cycle 0 is the cycle start is sampled high in IDLE. With T = NO_INPUT*NO_OUTPUT:
  - rd_en high in cycles 1..T, continuous.
  - mac_en high in cycles 2..T+1.
  - out_we for output j in cycle 1 + (j+1)*NO_INPUT + MAC_LAT.
  - Last out_we in cycle T+1+MAC_LAT.
  - done in cycle T+2+MAC_LAT.
- busy is high from cycle 1 through the last DRAIN cycle; it is low in the done cycle.
- Earliest next accepted start is the cycle after done, giving a pass period of T+3+MAC_LAT.
- All outputs are registered. Reset value of every output is 0.

## Test plan
- N=2, M=2, MAC_LAT=1, start pulse at cycle 0:
  - rd_en cycles 1-4 with (in_addr, w_addr) = (0,0), (1,2), (0,1), (1,3).
  - mac_clear at cycles 2 and 4; mac_last at cycles 3 and 5.
  - out_we at cycle 4 (addr 0) and cycle 6 (addr 1); done at cycle 7.
- N=1, M=3, MAC_LAT=1:
  - mac_en at cycles 2-4, each with clear and last.
  - out_we at cycles 3, 4, 5 with addr 0, 1, 2; done at cycle 6.
- N=3, M=1, MAC_LAT=3: single out_we at cycle 7, addr 0; done at cycle 8.
- start held high continuously from cycle 0, N=2, M=2, MAC_LAT=1:
  - Exactly one pass; start is ignored while busy.
  - Second pass starts with rd_en at cycle 9.
- rst asserted at cycle 3 of an N=2, M=2 pass: from cycle 4 all outputs are 0, no out_we, no done.
  - A later start runs a full, correct pass.
- start and rst high together in IDLE: block stays IDLE and all outputs stay 0.

Source files
------------

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: walks one shared MAC PE through a fully connected layer.
// Issues input/weight reads, PE strobes and output writes; start/busy/done handshake.
module fc_layer_sequencer #(
  parameter int NO_INPUT  = 2,
  parameter int NO_OUTPUT = 2,
  parameter int MAC_LAT   = 1,
  parameter int IW = (NO_INPUT > 1) ? $clog2(NO_INPUT) : 1,
  parameter int OW = (NO_OUTPUT > 1) ? $clog2(NO_OUTPUT) : 1,
  parameter int WW = (NO_INPUT * NO_OUTPUT > 1) ?
                     $clog2(NO_INPUT * NO_OUTPUT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [IW-1:0] in_addr,
  output logic [WW-1:0] w_addr,
  output logic          mac_en,
  output logic          mac_clear,
  output logic          mac_last,
  output logic          out_we,
  output logic [OW-1:0] out_addr
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [IW-1:0] I_LAST = IW'(NO_INPUT - 1);
  localparam logic [OW-1:0] J_LAST = OW'(NO_OUTPUT - 1);
  localparam logic [WW-1:0] W_STEP = WW'(NO_OUTPUT);
  // Only the oldest writeback stage occupied: the final write is on out_we now.
  localparam logic [MAC_LAT-1:0] WB_TOP = MAC_LAT'(1) << (MAC_LAT - 1);

  state_t        state;
  state_t        state_n;
  logic [OW-1:0] j_q;
  logic [IW-1:0] i_n;
  logic [OW-1:0] j_n;
  logic [WW-1:0] w_n;
  logic [OW-1:0] tag;
  logic [MAC_LAT-1:0] wb_v;
  logic [OW-1:0]      wb_tag [MAC_LAT];

  assign out_we   = wb_v[MAC_LAT-1];
  assign out_addr = wb_tag[MAC_LAT-1];

  // Next state and next read indices; the weight address steps by a row
  // per input and rewinds to the next column when i wraps.
  always_comb begin
    state_n = state;
    i_n     = '0;
    j_n     = '0;
    w_n     = '0;
    unique case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (in_addr == I_LAST && j_q == J_LAST) begin
          state_n = DRAIN;
        end else if (in_addr == I_LAST) begin
          j_n = j_q + OW'(1);
          w_n = WW'(j_q) + WW'(1);
        end else begin
          i_n = in_addr + IW'(1);
          j_n = j_q;
          w_n = w_addr + W_STEP;
        end
      end
      DRAIN: begin
        if (!mac_en && wb_v == WB_TOP) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, read side and handshake registers, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      in_addr <= '0;
      w_addr  <= '0;
      j_q     <= '0;
    end else begin
      state   <= state_n;
      busy    <= (state_n == RUN) || (state_n == DRAIN);
      done    <= (state_n == DONE);
      rd_en   <= (state_n == RUN);
      in_addr <= i_n;
      w_addr  <= w_n;
      j_q     <= j_n;
    end
  end

  // Issue stage lines up PE strobes with the 1-cycle memory read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_en    <= 1'b0;
      mac_clear <= 1'b0;
      mac_last  <= 1'b0;
      tag       <= '0;
    end else begin
      mac_en    <= rd_en;
      mac_clear <= rd_en && (in_addr == '0);
      mac_last  <= rd_en && (in_addr == I_LAST);
      tag       <= rd_en ? j_q : '0;
    end
  end

  // Writeback delay line; tags are zeroed on entry so out_addr is 0 when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_v <= '0;
      for (int k = 0; k < MAC_LAT; k++) wb_tag[k] <= '0;
    end else begin
      wb_v[0]   <= mac_last;
      wb_tag[0] <= mac_last ? tag : '0;
      for (int k = 1; k < MAC_LAT; k++) begin
        wb_v[k]   <= wb_v[k-1];
        wb_tag[k] <= wb_tag[k-1];
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: random start/rst on four layer shapes, each checked
// cycle by cycle against a timeline model computed from the pass start cycle.
module tb_fc_layer_sequencer;

  localparam int ND = 4;
  localparam int NCYC = 1500;
  localparam int NI_T [ND] = '{2, 1, 3, 3};
  localparam int NO_T [ND] = '{2, 3, 1, 2};
  localparam int ML_T [ND] = '{1, 1, 3, 2};

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] in_addr;
    logic [7:0] w_addr;
    logic       mac_en;
    logic       mac_clear;
    logic       mac_last;
    logic       out_we;
    logic [7:0] out_addr;
  } obs_t;

  logic clk = 1'b0;
  logic start_v [ND];
  logic rst_v [ND];
  obs_t obs [ND];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int NI = NI_T[g];
    localparam int NO = NO_T[g];
    localparam int ML = ML_T[g];
    localparam int IW = (NI > 1) ? $clog2(NI) : 1;
    localparam int OW = (NO > 1) ? $clog2(NO) : 1;
    localparam int WW = (NI * NO > 1) ? $clog2(NI * NO) : 1;
    logic busy, done, rd_en, mac_en, mac_clear, mac_last, out_we;
    logic [IW-1:0] in_addr;
    logic [WW-1:0] w_addr;
    logic [OW-1:0] out_addr;

    fc_layer_sequencer #(
      .NO_INPUT(NI),
      .NO_OUTPUT(NO),
      .MAC_LAT(ML)
    ) u_dut (
      .clk(clk),
      .rst(rst_v[g]),
      .start(start_v[g]),
      .busy(busy),
      .done(done),
      .rd_en(rd_en),
      .in_addr(in_addr),
      .w_addr(w_addr),
      .mac_en(mac_en),
      .mac_clear(mac_clear),
      .mac_last(mac_last),
      .out_we(out_we),
      .out_addr(out_addr)
    );

    assign obs[g] = {busy, done, rd_en, 8'(in_addr), 8'(w_addr),
                     mac_en, mac_clear, mac_last, out_we, 8'(out_addr)};
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Expected outputs t cycles after start was accepted (t<0: no pass).
  function automatic obs_t exp_f(int n, int m, int l, int t);
    obs_t e;
    int tt;
    int k;
    e = '0;
    tt = n * m;
    if (t >= 1 && t <= tt + 1 + l) e.busy = 1'b1;
    if (t == tt + 2 + l) e.done = 1'b1;
    if (t >= 1 && t <= tt) begin
      k = t - 1;
      e.rd_en   = 1'b1;
      e.in_addr = 8'(k % n);
      e.w_addr  = 8'((k % n) * m + k / n);
    end
    if (t >= 2 && t <= tt + 1) begin
      k = t - 2;
      e.mac_en    = 1'b1;
      e.mac_clear = (k % n == 0);
      e.mac_last  = (k % n == n - 1);
    end
    for (int j = 0; j < m; j++) begin
      if (t == 1 + (j + 1) * n + l) begin
        e.out_we   = 1'b1;
        e.out_addr = 8'(j);
      end
    end
    return e;
  endfunction

  initial begin
    bit   act [ND];
    int   s [ND];
    int   dens [ND];
    int   t;
    int   per;
    bit   r;
    bit   st;
    obs_t e;
    obs_t o;
    string p;

    for (int g = 0; g < ND; g++) begin
      start_v[g] = 1'b0;
      rst_v[g]   = 1'b1;
      act[g]     = 1'b0;
      s[g]       = 0;
      dens[g]    = 1;
    end
    repeat (2) @(posedge clk);

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      for (int g = 0; g < ND; g++) begin
        t = act[g] ? c - s[g] : -1;
        e = exp_f(NI_T[g], NO_T[g], ML_T[g], t);
        o = obs[g];
        p = $sformatf("d%0d.c%0d", g, c);
        chk({p, ".busy"}, 32'(o.busy), 32'(e.busy));
        chk({p, ".done"}, 32'(o.done), 32'(e.done));
        chk({p, ".rd_en"}, 32'(o.rd_en), 32'(e.rd_en));
        chk({p, ".in_addr"}, 32'(o.in_addr), 32'(e.in_addr));
        chk({p, ".w_addr"}, 32'(o.w_addr), 32'(e.w_addr));
        chk({p, ".mac_en"}, 32'(o.mac_en), 32'(e.mac_en));
        chk({p, ".mac_clear"}, 32'(o.mac_clear), 32'(e.mac_clear));
        chk({p, ".mac_last"}, 32'(o.mac_last), 32'(e.mac_last));
        chk({p, ".out_we"}, 32'(o.out_we), 32'(e.out_we));
        chk({p, ".out_addr"}, 32'(o.out_addr), 32'(e.out_addr));
      end
      for (int g = 0; g < ND; g++) begin
        if (c % 150 == 0) dens[g] = $urandom_range(0, 4);
        r  = ($urandom_range(0, 39) == 0);
        st = ($urandom_range(0, 3) < dens[g]);
        rst_v[g]   = r;
        start_v[g] = st;
        per = NI_T[g] * NO_T[g] + 3 + ML_T[g];
        if (r) begin
          act[g] = 1'b0;
        end else if (st && (!act[g] || c - s[g] >= per)) begin
          act[g] = 1'b1;
          s[g]   = c;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
